// File: rtl/push_pop_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : push_pop_sequencer
// Brief   : Cracks Thumb PUSH/POP into one load/store micro-op per listed
//           register followed by a single SP-adjust micro-op.
// Rev     : 1.0  initial release
// ============================================================================
module push_pop_sequencer #(
   parameter int WORD        = 32,
   parameter int ADDR_WIDTH  = 4,
   parameter int INSTR_WIDTH = 16,
   parameter int SP_ADDR     = 13,
   parameter int LR_ADDR     = 14,
   parameter int PC_ADDR     = 15
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   is_valid_i,
   input  logic [INSTR_WIDTH-1:0] instruction_i,
   input  logic                   hold_i,
   input  logic                   flush_i,
   output logic                   busy_o,
   output logic                   stall_fetch_o,
   output logic                   uop_valid_o,
   output logic                   uop_store_o,
   output logic                   uop_load_o,
   output logic                   uop_sp_update_o,
   output logic [ADDR_WIDTH-1:0]  uop_reg_addr_o,
   output logic [WORD-1:0]        uop_offset_o,
   output logic                   uop_branch_o,
   output logic                   uop_last_o
);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_xfer  = 2'd1;
   localparam logic [1:0] c_st_spupd = 2'd2;

   logic [1:0]            r_state, w_state_nxt;
   logic [8:0]            r_list, w_list_nxt;
   logic [3:0]            r_n, w_n_nxt;
   logic [3:0]            r_k, w_k_nxt;
   logic                  r_push, w_push_nxt;

   logic                  r_valid, r_store, r_load, r_sp, r_branch, r_last;
   logic [ADDR_WIDTH-1:0] r_reg;
   logic [WORD-1:0]       r_off;
   logic                  w_valid_nxt, w_store_nxt, w_load_nxt, w_sp_nxt;
   logic                  w_branch_nxt, w_last_nxt;
   logic [ADDR_WIDTH-1:0] w_reg_nxt;
   logic [WORD-1:0]       w_off_nxt;

   logic                  w_is_push, w_is_pop, w_accept;
   logic [8:0]            w_list;
   logic [3:0]            w_n;

   logic [8:0]            w_src_list, w_rem;
   logic [3:0]            w_src_n, w_src_k, w_idx;
   logic                  w_src_push;
   logic [ADDR_WIDTH-1:0] w_reg_xfer;
   logic [WORD-1:0]       w_k4, w_n4, w_rn4, w_off_xfer, w_off_sp;

   function automatic logic [3:0] f_lowest(input logic [8:0] l);
      f_lowest = 4'd0;
      for (int i = 8; i >= 0; i--) begin
         if (l[i]) f_lowest = 4'(i);
      end
   endfunction

   // Instruction decode
   assign w_is_push = (instruction_i[15:9] == 7'b1011010);
   assign w_is_pop  = (instruction_i[15:9] == 7'b1011110);
   assign w_list    = instruction_i[8:0];

   always_comb begin
      w_n = 4'd0;
      for (int i = 0; i < 9; i++) w_n = w_n + {3'b000, w_list[i]};
   end

   assign w_accept = (r_state == c_st_idle) & is_valid_i & (w_is_push | w_is_pop)
                   & (w_n != 4'd0) & ~hold_i & ~flush_i;

   // In IDLE the next transfer comes straight from the instruction, else from the latched list
   assign w_src_list = (r_state == c_st_idle) ? w_list    : r_list;
   assign w_src_n    = (r_state == c_st_idle) ? w_n       : r_n;
   assign w_src_k    = (r_state == c_st_idle) ? 4'd0      : r_k + 4'd1;
   assign w_src_push = (r_state == c_st_idle) ? w_is_push : r_push;

   assign w_idx      = f_lowest(w_src_list);
   assign w_rem      = w_src_list & (w_src_list - 9'd1);
   assign w_reg_xfer = (w_idx == 4'd8)
                     ? (w_src_push ? ADDR_WIDTH'(LR_ADDR) : ADDR_WIDTH'(PC_ADDR))
                     : ADDR_WIDTH'(w_idx);

   assign w_k4       = {{(WORD-6){1'b0}}, w_src_k, 2'b00};
   assign w_n4       = {{(WORD-6){1'b0}}, w_src_n, 2'b00};
   assign w_rn4      = {{(WORD-6){1'b0}}, r_n, 2'b00};
   assign w_off_xfer = w_src_push ? (w_k4 - w_n4) : w_k4;
   assign w_off_sp   = r_push ? (-w_rn4) : w_rn4;

   // State register
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) r_state <= c_st_idle;
      else          r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle:  if (w_accept) w_state_nxt = c_st_xfer;
         c_st_xfer: begin
            if (flush_i)                          w_state_nxt = c_st_idle;
            else if (!hold_i && r_list == 9'd0)   w_state_nxt = c_st_spupd;
         end
         c_st_spupd: if (flush_i || !hold_i) w_state_nxt = c_st_idle;
         default:    w_state_nxt = c_st_idle;
      endcase
   end

   // Output / datapath next values; default is to freeze everything
   always_comb begin
      w_list_nxt   = r_list;
      w_n_nxt      = r_n;
      w_k_nxt      = r_k;
      w_push_nxt   = r_push;
      w_valid_nxt  = r_valid;
      w_store_nxt  = r_store;
      w_load_nxt   = r_load;
      w_sp_nxt     = r_sp;
      w_reg_nxt    = r_reg;
      w_off_nxt    = r_off;
      w_branch_nxt = r_branch;
      w_last_nxt   = r_last;
      if (flush_i || (!hold_i && (r_state == c_st_spupd || (r_state == c_st_idle && !w_accept)))) begin
         w_valid_nxt  = 1'b0;
         w_store_nxt  = 1'b0;
         w_load_nxt   = 1'b0;
         w_sp_nxt     = 1'b0;
         w_reg_nxt    = '0;
         w_off_nxt    = '0;
         w_branch_nxt = 1'b0;
         w_last_nxt   = 1'b0;
         if (flush_i) begin
            w_list_nxt = 9'd0;
            w_n_nxt    = 4'd0;
            w_k_nxt    = 4'd0;
            w_push_nxt = 1'b0;
         end
      end else if (!hold_i && (w_accept || (r_state == c_st_xfer && r_list != 9'd0))) begin
         w_list_nxt   = w_rem;
         w_n_nxt      = w_src_n;
         w_k_nxt      = w_src_k;
         w_push_nxt   = w_src_push;
         w_valid_nxt  = 1'b1;
         w_store_nxt  = w_src_push;
         w_load_nxt   = ~w_src_push;
         w_sp_nxt     = 1'b0;
         w_reg_nxt    = w_reg_xfer;
         w_off_nxt    = w_off_xfer;
         w_branch_nxt = ~w_src_push & (w_reg_xfer == ADDR_WIDTH'(PC_ADDR));
         w_last_nxt   = 1'b0;
      end else if (!hold_i && r_state == c_st_xfer) begin
         w_valid_nxt  = 1'b1;
         w_store_nxt  = 1'b0;
         w_load_nxt   = 1'b0;
         w_sp_nxt     = 1'b1;
         w_reg_nxt    = ADDR_WIDTH'(SP_ADDR);
         w_off_nxt    = w_off_sp;
         w_branch_nxt = 1'b0;
         w_last_nxt   = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_list   <= 9'd0;
         r_n      <= 4'd0;
         r_k      <= 4'd0;
         r_push   <= 1'b0;
         r_valid  <= 1'b0;
         r_store  <= 1'b0;
         r_load   <= 1'b0;
         r_sp     <= 1'b0;
         r_reg    <= '0;
         r_off    <= '0;
         r_branch <= 1'b0;
         r_last   <= 1'b0;
      end else begin
         r_list   <= w_list_nxt;
         r_n      <= w_n_nxt;
         r_k      <= w_k_nxt;
         r_push   <= w_push_nxt;
         r_valid  <= w_valid_nxt;
         r_store  <= w_store_nxt;
         r_load   <= w_load_nxt;
         r_sp     <= w_sp_nxt;
         r_reg    <= w_reg_nxt;
         r_off    <= w_off_nxt;
         r_branch <= w_branch_nxt;
         r_last   <= w_last_nxt;
      end
   end

   assign busy_o          = (r_state != c_st_idle);
   assign stall_fetch_o   = w_accept | (r_state == c_st_xfer);
   assign uop_valid_o     = r_valid;
   assign uop_store_o     = r_store;
   assign uop_load_o      = r_load;
   assign uop_sp_update_o = r_sp;
   assign uop_reg_addr_o  = r_reg;
   assign uop_offset_o    = r_off;
   assign uop_branch_o    = r_branch;
   assign uop_last_o      = r_last;

endmodule
`default_nettype wire
